// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light codes, phase encodings and head decode
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_NS_G   = 3'd1,
        ST_NS_Y   = 3'd2,
        ST_EW_G   = 3'd3,
        ST_EW_Y   = 3'd4,
        ST_WALK   = 3'd5
    } phase_e;

    function automatic logic [1:0] head_code(input phase_e st, input phase_e green_st,
                                             input phase_e yellow_st);
        if (st == green_st) begin
            return GREEN;
        end
        if (st == yellow_st) begin
            return YELLOW;
        end
        return RED;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// rtl/traffic_phase_scheduler_if.sv - request inputs and lamp outputs of the phase scheduler
interface traffic_phase_scheduler_if;

    logic       ped_req;
    logic       emg_req;
    logic       emg_dir;
    logic [1:0] NS;
    logic [1:0] EW;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output ped_req, emg_req, emg_dir,
        input  NS, EW, walk, ped_ack, phase
    );

    modport slave (
        input  ped_req, emg_req, emg_dir,
        output NS, EW, walk, ped_ack, phase
    );

endinterface

// File: rtl/traffic_tick_gen.sv
// rtl/traffic_tick_gen.sv - TICK_DIV prescaler emitting a one-cycle tick, with clear and freeze
module traffic_tick_gen #(
    parameter int unsigned TICK_DIV = 2080000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    assign tick_o = en_i && (count_q == LAST);

    // Clear wins over counting so a new phase always starts a full tick period.
    always_comb begin
        count_d = count_q;
        if (clr_i || tick_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - intersection phase sequencer with walk and emergency pre-empt
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 2080000,
    parameter int unsigned GREEN_T  = 20,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 10
) (
    input logic                      clk,
    input logic                      reset,
    traffic_phase_scheduler_if.slave bus
);

    localparam int unsigned MAX_A = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int unsigned MAX_B = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW    = $clog2(MAX_T + 1);

    logic [2:0]    ped_sync_q;
    logic [1:0]    emg_sync_q;
    logic [1:0]    dir_sync_q;
    logic          ped_rise;
    logic          emg_s;
    logic          dir_s;

    phase_e        state_q;
    phase_e        state_d;
    logic          next_dir_q;
    logic          next_dir_d;
    logic          ped_pend_q;
    logic          ped_pend_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    logic          tick;
    logic          freeze;
    logic          expire;
    logic          state_change;
    logic          enter_walk;

    logic [1:0]    ns_q;
    logic [1:0]    ew_q;
    logic          walk_q;
    logic          ack_q;

    function automatic logic [TW-1:0] phase_dur(input phase_e st);
        case (st)
            ST_NS_G, ST_EW_G: phase_dur = TW'(GREEN_T);
            ST_NS_Y, ST_EW_Y: phase_dur = TW'(YELLOW_T);
            ST_WALK:          phase_dur = TW'(WALK_T);
            default:          phase_dur = TW'(ALLRED_T);
        endcase
    endfunction

    // ped_sync_q[2] is the previous synchronized level, used for edge detection only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_sync_q <= '0;
            emg_sync_q <= '0;
            dir_sync_q <= '0;
        end else begin
            ped_sync_q <= {ped_sync_q[1:0], bus.ped_req};
            emg_sync_q <= {emg_sync_q[0], bus.emg_req};
            dir_sync_q <= {dir_sync_q[0], bus.emg_dir};
        end
    end

    assign ped_rise = ped_sync_q[1] & ~ped_sync_q[2];
    assign emg_s    = emg_sync_q[1];
    assign dir_s    = dir_sync_q[1];

    assign freeze = emg_s && (((state_q == ST_NS_G) && !dir_s) ||
                              ((state_q == ST_EW_G) &&  dir_s));

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_change),
        .en_i   (~freeze),
        .tick_o (tick)
    );

    assign expire = tick && (timer_q <= TW'(1));

    always_comb begin
        state_d    = state_q;
        next_dir_d = next_dir_q;
        case (state_q)
            ST_ALLRED: begin
                if (expire) begin
                    if (emg_s) begin
                        state_d    = dir_s ? ST_EW_G : ST_NS_G;
                        next_dir_d = dir_s;
                    end else if (ped_pend_q) begin
                        state_d = ST_WALK;
                    end else begin
                        state_d = next_dir_q ? ST_EW_G : ST_NS_G;
                    end
                end
            end
            // A conflicting pre-empt aborts green at once; a matching one only freezes it.
            ST_NS_G: begin
                if ((emg_s && dir_s) || expire) begin
                    state_d = ST_NS_Y;
                end
            end
            ST_EW_G: begin
                if ((emg_s && !dir_s) || expire) begin
                    state_d = ST_EW_Y;
                end
            end
            ST_NS_Y: begin
                if (expire) begin
                    state_d    = ST_ALLRED;
                    next_dir_d = 1'b1;
                end
            end
            ST_EW_Y: begin
                if (expire) begin
                    state_d    = ST_ALLRED;
                    next_dir_d = 1'b0;
                end
            end
            ST_WALK: begin
                if (expire) begin
                    state_d = ST_ALLRED;
                end
            end
            default: begin
                state_d = ST_ALLRED;
            end
        endcase
    end

    assign state_change = (state_d != state_q);
    assign enter_walk   = (state_d == ST_WALK) && (state_q != ST_WALK);
    assign ped_pend_d   = (ped_pend_q & ~enter_walk) | ped_rise;

    always_comb begin
        timer_d = timer_q;
        if (state_change) begin
            timer_d = phase_dur(state_d);
        end else if (tick) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ALLRED;
            next_dir_q <= 1'b0;
            ped_pend_q <= 1'b0;
            timer_q    <= TW'(ALLRED_T);
        end else begin
            state_q    <= state_d;
            next_dir_q <= next_dir_d;
            ped_pend_q <= ped_pend_d;
            timer_q    <= timer_d;
        end
    end

    // Lamp registers decode the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ns_q   <= RED;
            ew_q   <= RED;
            walk_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ns_q   <= head_code(state_d, ST_NS_G, ST_NS_Y);
            ew_q   <= head_code(state_d, ST_EW_G, ST_EW_Y);
            walk_q <= (state_d == ST_WALK);
            ack_q  <= enter_walk;
        end
    end

    assign bus.NS      = ns_q;
    assign bus.EW      = ew_q;
    assign bus.walk    = walk_q;
    assign bus.ped_ack = ack_q;
    assign bus.phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scenario table plus randomized model comparison
module tb_traffic_phase_scheduler;

    localparam int DIV = 4;
    localparam int GT  = 5;
    localparam int YT  = 2;
    localparam int AT  = 1;
    localparam int WT  = 3;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;

    localparam int K_ALLRED = 0;
    localparam int K_GRN    = 1;
    localparam int K_YEL    = 2;
    localparam int K_WALK   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    traffic_phase_scheduler_if bus ();

    traffic_phase_scheduler #(
        .TICK_DIV (DIV),
        .GREEN_T  (GT),
        .YELLOW_T (YT),
        .ALLRED_T (AT),
        .WALK_T   (WT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        int         n;
        bit         ped;
        bit         emg;
        bit         dir;
        logic [1:0] ns;
        logic [1:0] ew;
        bit         walk;
        bit         ack;
    } seg_t;

    seg_t tbl[$];

    function automatic seg_t sg(int n, bit ped, bit emg, bit dir, logic [1:0] ns,
                                logic [1:0] ew, bit walk, bit ack);
        seg_t s;
        s.rst = 1'b0; s.n = n; s.ped = ped; s.emg = emg; s.dir = dir;
        s.ns = ns; s.ew = ew; s.walk = walk; s.ack = ack;
        return s;
    endfunction

    function automatic seg_t rs();
        seg_t s;
        s = sg(0, 0, 0, 0, R, R, 0, 0);
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input logic [1:0] ns, input logic [1:0] ew,
                         input logic walk, input logic ack);
        n_vec++;
        if (bus.NS !== ns || bus.EW !== ew || bus.walk !== walk || bus.ped_ack !== ack) begin
            n_bad++;
            $display("FAIL %s t=%0t: got NS=%b EW=%b walk=%b ack=%b, want NS=%b EW=%b walk=%b ack=%b",
                     name, $time, bus.NS, bus.EW, bus.walk, bus.ped_ack, ns, ew, walk, ack);
        end
    endtask

    // Called at a negedge; reset is asserted between edges and must act immediately.
    task automatic do_reset();
        bus.ped_req = 1'b0;
        bus.emg_req = 1'b0;
        bus.emg_dir = 1'b0;
        reset = 1'b0;
        #1;
        check("async_reset", R, R, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Reference model: phase kind + direction, remaining time counted in whole clock cycles.
    int m_kind, m_dir, m_next, m_rem;
    bit m_pend, m_ack;
    bit m_ped[3];
    bit m_emg[2];
    bit m_edir[2];

    function automatic int m_len(int kind);
        case (kind)
            K_GRN:   return GT * DIV;
            K_YEL:   return YT * DIV;
            K_WALK:  return WT * DIV;
            default: return AT * DIV;
        endcase
    endfunction

    task automatic model_reset();
        m_kind = K_ALLRED; m_dir = 0; m_next = 0; m_rem = m_len(K_ALLRED);
        m_pend = 0; m_ack = 0;
        m_ped = '{0, 0, 0}; m_emg = '{0, 0}; m_edir = '{0, 0};
    endtask

    task automatic model_step(input bit ped, input bit emg, input bit dir);
        bit rise, e, d, entered_walk;
        rise = m_ped[1] & ~m_ped[2];
        e = m_emg[1];
        d = m_edir[1];
        entered_walk = 0;
        if (m_kind == K_GRN && e && d != m_dir[0]) begin
            m_kind = K_YEL;
            m_rem = m_len(K_YEL);
        end else if (!(m_kind == K_GRN && e && d == m_dir[0])) begin
            if (m_rem > 1) begin
                m_rem--;
            end else begin
                case (m_kind)
                    K_ALLRED: begin
                        if (e) begin
                            m_kind = K_GRN; m_dir = d; m_next = d;
                        end else if (m_pend) begin
                            m_kind = K_WALK; entered_walk = 1;
                        end else begin
                            m_kind = K_GRN; m_dir = m_next;
                        end
                    end
                    K_GRN:   m_kind = K_YEL;
                    K_YEL:   begin m_kind = K_ALLRED; m_next = 1 - m_dir; end
                    default: m_kind = K_ALLRED;
                endcase
                m_rem = m_len(m_kind);
            end
        end
        m_ack = entered_walk;
        m_pend = (m_pend & ~entered_walk) | rise;
        m_ped[2] = m_ped[1]; m_ped[1] = m_ped[0]; m_ped[0] = ped;
        m_emg[1] = m_emg[0]; m_emg[0] = emg;
        m_edir[1] = m_edir[0]; m_edir[0] = dir;
    endtask

    function automatic logic [1:0] m_head(int d);
        if (m_kind == K_GRN && m_dir == d) return G;
        if (m_kind == K_YEL && m_dir == d) return Y;
        return R;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ped_lvl, emg_lvl, dir_lvl, pulse;

        // Free-running alternation
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, G,R,0,0));
        tbl.push_back(sg(8, 0,0,0, Y,R,0,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, R,G,0,0));
        tbl.push_back(sg(8, 0,0,0, R,Y,0,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, G,R,0,0));
        // One-cycle pedestrian press during NS green
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(5, 0,0,0, G,R,0,0));
        tbl.push_back(sg(1, 1,0,0, G,R,0,0));
        tbl.push_back(sg(14,0,0,0, G,R,0,0));
        tbl.push_back(sg(8, 0,0,0, Y,R,0,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(1, 0,0,0, R,R,1,1));
        tbl.push_back(sg(11,0,0,0, R,R,1,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, R,G,0,0));
        // EW pre-empt mid NS green: abort, then freeze EW green while held
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(10,0,0,0, G,R,0,0));
        tbl.push_back(sg(3, 0,1,1, G,R,0,0));
        tbl.push_back(sg(8, 0,1,1, Y,R,0,0));
        tbl.push_back(sg(4, 0,1,1, R,R,0,0));
        tbl.push_back(sg(100,0,1,1, R,G,0,0));
        tbl.push_back(sg(22,0,0,0, R,G,0,0));
        tbl.push_back(sg(8, 0,0,0, R,Y,0,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, G,R,0,0));
        // Pedestrian and NS emergency both pending at all-red expiry
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, G,R,0,0));
        tbl.push_back(sg(1, 1,0,0, Y,R,0,0));
        tbl.push_back(sg(7, 0,0,0, Y,R,0,0));
        tbl.push_back(sg(4, 0,1,0, R,R,0,0));
        tbl.push_back(sg(10,0,1,0, G,R,0,0));
        tbl.push_back(sg(22,0,0,0, G,R,0,0));
        tbl.push_back(sg(8, 0,0,0, Y,R,0,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(1, 0,0,0, R,R,1,1));
        tbl.push_back(sg(11,0,0,0, R,R,1,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, R,G,0,0));
        // Pedestrian button held: exactly one walk
        tbl.push_back(rs());
        tbl.push_back(sg(4, 1,0,0, R,R,0,0));
        tbl.push_back(sg(1, 1,0,0, R,R,1,1));
        tbl.push_back(sg(11,1,0,0, R,R,1,0));
        tbl.push_back(sg(4, 1,0,0, R,R,0,0));
        tbl.push_back(sg(20,1,0,0, G,R,0,0));
        tbl.push_back(sg(8, 1,0,0, Y,R,0,0));
        tbl.push_back(sg(4, 1,0,0, R,R,0,0));
        tbl.push_back(sg(20,1,0,0, R,G,0,0));
        // Reset mid NS yellow, then the normal sequence again
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, G,R,0,0));
        tbl.push_back(sg(3, 0,0,0, Y,R,0,0));
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, G,R,0,0));
        tbl.push_back(sg(8, 0,0,0, Y,R,0,0));
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(20,0,0,0, R,G,0,0));
        // Reset during the first walk cycle clears walk and ped_ack at once
        tbl.push_back(rs());
        tbl.push_back(sg(4, 1,0,0, R,R,0,0));
        tbl.push_back(rs());
        tbl.push_back(sg(4, 0,0,0, R,R,0,0));
        tbl.push_back(sg(4, 0,0,0, G,R,0,0));

        bus.ped_req = 1'b0;
        bus.emg_req = 1'b0;
        bus.emg_dir = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset();
            end
            for (int c = 0; c < tbl[i].n; c++) begin
                check($sformatf("seg%0d.cyc%0d", i, c), tbl[i].ns, tbl[i].ew,
                      tbl[i].walk, tbl[i].ack);
                bus.ped_req = tbl[i].ped;
                bus.emg_req = tbl[i].emg;
                bus.emg_dir = tbl[i].dir;
                @(posedge clk);
                @(negedge clk);
            end
        end

        for (int run = 0; run < 3; run++) begin
            do_reset();
            model_reset();
            ped_lvl = 0; emg_lvl = 0; dir_lvl = 0;
            for (int c = 0; c < 1500; c++) begin
                check($sformatf("rand%0d.cyc%0d", run, c), m_head(0), m_head(1),
                      m_kind == K_WALK, m_ack);
                n_vec++;
                if (bus.NS != R && bus.EW != R) begin
                    n_bad++;
                    $display("FAIL conflict rand%0d.cyc%0d: NS=%b EW=%b both lit, required one RED",
                             run, c, bus.NS, bus.EW);
                end
                if ($urandom_range(0, 39) == 0) ped_lvl = ~ped_lvl;
                pulse = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 79) == 0) emg_lvl = ~emg_lvl;
                if ($urandom_range(0, 49) == 0) dir_lvl = ~dir_lvl;
                bus.ped_req = ped_lvl | pulse;
                bus.emg_req = emg_lvl;
                bus.emg_dir = dir_lvl;
                model_step(ped_lvl | pulse, emg_lvl, dir_lvl);
                @(posedge clk);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
